audio_i2s_tx: RTL and testbench
===============================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width per channel (8..32).
REQ-002 SHALL have parameter BCLK_DIV, default 6, refclk cycles per BCLK period (even, >=4).
REQ-003 SHALL have parameter LOCK_WAIT, default 1024, consecutive locked cycles required before running.
REQ-004 SHALL have port refclk, input, 1, the 18.432 MHz audio master clock, and the only clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port pll_locked, input, 1, lock status of the clock source, synchronous to refclk.
REQ-007 SHALL have ports sample_l and sample_r, input, DATA_W each, the left and right samples, two's complement.
REQ-008 SHALL have port sample_valid, input, 1, sample pair offered.
REQ-009 SHALL have port sample_ready, output, 1, sample pair can be accepted.
REQ-010 SHALL have ports bclk, lrclk and dacdat, output, 1 each, I2S bit clock, word select (0 = left) and serial data.
REQ-011 SHALL have port underrun, output, 1, one-cycle pulse when a frame starts with no sample pair buffered.
REQ-012 SHALL have port running, output, 1, high while in RUN.

Function
REQ-013 SHALL implement two states, WAIT_LOCK and RUN; reset enters WAIT_LOCK.
REQ-014 WAIT_LOCK SHALL count consecutive pll_locked=1 cycles; pll_locked=0 SHALL clear the count; a count reaching LOCK_WAIT SHALL move to RUN on the next cycle.
REQ-015 RUN SHALL return to WAIT_LOCK in the cycle after pll_locked=0 is sampled; all outputs low, the holding register emptied, counters cleared.
REQ-016 In RUN, div_cnt SHALL count 0..BCLK_DIV-1 and wrap; bclk is 0 for div_cnt < BCLK_DIV/2 and 1 otherwise (registered).
REQ-017 bit_cnt (6 bits) SHALL increment when div_cnt wraps (a bclk falling edge) and wrap 63->0; lrclk = bit_cnt[5]; a frame is 64 BCLK = 384 refclk at defaults (48 kHz).
REQ-018 A frame start SHALL be the RUN cycle with div_cnt=0 and bit_cnt=0; the first RUN cycle is a frame start.
REQ-019 Serial format SHALL be I2S: at slot position p (bit_cnt[4:0]) = 1..DATA_W, dacdat = word bit DATA_W-p (MSB first, one BCLK after the lrclk edge); every other position is 0.
REQ-020 dacdat and lrclk SHALL change only on bclk falling edges.
REQ-021 SHALL use a one-entry holding register; sample_ready = RUN and holding register empty; a pair is accepted on sample_valid and sample_ready.
REQ-022 At frame start, a full holding register SHALL load into the shift register and empty; an empty one SHALL pulse underrun for one cycle and transmit the underrun frame (REQ-026).
REQ-023 Frame start decisions SHALL use the registered full flag; a pair accepted in the frame-start cycle waits for the next frame, and underrun still pulses.
REQ-024 sample_l and sample_r SHALL be captured together; a pair is never split across frames.

Reset
REQ-025 rst SHALL clear the state (WAIT_LOCK), lock count, div_cnt, bit_cnt, holding register, shift register and last-frame store; bclk, lrclk, dacdat, sample_ready, underrun and running are all 0.

Configuration
REQ-026 Macro AUDIO_TX_UNDERRUN_REPEAT_EN: when defined, an underrun frame retransmits the last loaded pair (zeros if none since reset or relock); when undefined, it transmits all zeros. underrun pulses in both cases.

Verification
REQ-027 LOCK_WAIT=16, pll_locked high from reset with a one-cycle low at cycle 10 -> running rises exactly 17 cycles after the glitch, not earlier.
REQ-028 Steady RUN -> bclk period 6 refclk with a 3/3 duty cycle, lrclk period 384 refclk, every lrclk edge coincident with a bclk falling edge.
REQ-029 Pair L=16'hA5C3, R=16'h8001 buffered before a frame -> left slot position 0 = 0, positions 1..16 = A5C3 MSB first, 17..31 = 0; right slot carries 8001 the same way.
REQ-030 No pair offered -> underrun high for exactly 1 cycle at each frame start; dacdat all 0 (macro undefined) or the previous pair repeated (macro defined).
REQ-031 sample_valid held high with two distinct pairs -> the second pair is held off (sample_ready=0) until the frame start that loads the first; frames carry them in order.
REQ-032 pll_locked dropped mid right slot -> next cycle bclk=lrclk=dacdat=sample_ready=running=0; after relock the first frame starts with the left slot and underrun=1.

Source files
------------

// File: rtl/audio_i2s_tx_if.sv
// Sample-pair handshake between an audio source (master) and audio_i2s_tx (slave).
interface audio_i2s_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ready;

    modport master (output sample_l, sample_r, sample_valid, input sample_ready);
    modport slave  (input sample_l, sample_r, sample_valid, output sample_ready);
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S transmitter with a one-entry sample holding register, gated by PLL lock.
// Optional macro AUDIO_TX_UNDERRUN_REPEAT_EN: underrun frames repeat the last pair instead of zeros.
module audio_i2s_tx #(
    parameter int DATA_W    = 16,
    parameter int BCLK_DIV  = 6,
    parameter int LOCK_WAIT = 1024
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          pll_locked,
    audio_i2s_tx_if.slave smp,
    output logic          bclk,
    output logic          lrclk,
    output logic          dacdat,
    output logic          underrun,
    output logic          running
);
    localparam int LOCK_W = $clog2(LOCK_WAIT + 1);
    localparam int DIV_W  = $clog2(BCLK_DIV);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_WAIT);
    localparam logic [DIV_W-1:0]  LAST_DIV = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  HALF_DIV = DIV_W'(BCLK_DIV / 2);
    localparam logic [5:0]        WORD_END = 6'(DATA_W);

    typedef enum logic {WAIT_LOCK, RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [LOCK_W-1:0] lock_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic [5:0]        bit_cnt;
    logic [5:0]        bit_next;
    logic [4:0]        slot_pos;
    logic              div_wrap;
    logic              in_word;
    logic              run_ok;
    logic              frame_start;
    logic              accept;
    logic              full;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] frame_r;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] under_l;
    logic [DATA_W-1:0] under_r;
    logic [DATA_W-1:0] load_l;
    logic [DATA_W-1:0] load_r;

    always_ff @(posedge refclk) begin
        if (rst) state <= WAIT_LOCK;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_LOCK: if (pll_locked && lock_cnt == LOCK_MAX) state_next = RUN;
            RUN:       if (!pll_locked) state_next = WAIT_LOCK;
            default:   state_next = WAIT_LOCK;
        endcase
    end

    // Lock counter saturates at LOCK_WAIT; one more locked cycle then enters RUN.
    always_ff @(posedge refclk) begin
        if (rst || state == RUN || !pll_locked) lock_cnt <= '0;
        else if (lock_cnt != LOCK_MAX)          lock_cnt <= lock_cnt + 1'b1;
    end

    assign run_ok           = (state == RUN) && pll_locked;
    assign running          = (state == RUN);
    assign frame_start      = (state == RUN) && (div_cnt == '0) && (bit_cnt == '0);
    assign div_wrap         = (div_cnt == LAST_DIV);
    assign div_next         = div_wrap ? '0 : div_cnt + 1'b1;
    assign bit_next         = div_wrap ? bit_cnt + 6'd1 : bit_cnt;
    assign slot_pos         = bit_next[4:0];
    assign in_word          = (slot_pos != 5'd0) && ({1'b0, slot_pos} <= WORD_END);
    assign smp.sample_ready = (state == RUN) && !full;
    assign accept           = smp.sample_valid && smp.sample_ready;
    assign underrun         = frame_start && !full;
    assign load_l           = full ? hold_l : under_l;
    assign load_r           = full ? hold_r : under_r;

`ifdef AUDIO_TX_UNDERRUN_REPEAT_EN
    logic [DATA_W-1:0] last_l;

    always_ff @(posedge refclk) begin
        if (rst || !run_ok)   last_l <= '0;
        else if (frame_start) last_l <= load_l;
    end

    assign under_l = last_l;
    assign under_r = frame_r;
`else
    assign under_l = '0;
    assign under_r = '0;
`endif

    // Serialiser: the left word goes straight into shreg at frame start, the right
    // word waits in frame_r until the lrclk edge; outputs move only on bclk falls.
    always_ff @(posedge refclk) begin
        if (rst || !run_ok) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
            dacdat  <= 1'b0;
            full    <= 1'b0;
            hold_l  <= '0;
            hold_r  <= '0;
            frame_r <= '0;
            shreg   <= '0;
        end else begin
            div_cnt <= div_next;
            bit_cnt <= bit_next;
            bclk    <= (div_next >= HALF_DIV);
            if (div_wrap) begin
                lrclk <= bit_next[5];
                if (in_word) begin
                    dacdat <= shreg[DATA_W-1];
                    shreg  <= shreg << 1;
                end else begin
                    dacdat <= 1'b0;
                    if (bit_next == 6'd32) shreg <= frame_r;
                end
            end
            if (frame_start) begin
                shreg   <= load_l;
                frame_r <= load_r;
                full    <= 1'b0;
            end
            if (accept) begin
                hold_l <= smp.sample_l;
                hold_r <= smp.sample_r;
                full   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: random sample pairs, lock glitches and a mid-frame
// PLL drop, checked every cycle against a time-indexed model of the I2S stream.
`timescale 1ns/1ps
module tb_audio_i2s_tx;
    localparam int DATA_W    = 16;
    localparam int BCLK_DIV  = 6;
    localparam int LOCK_WAIT = 16;
    localparam int FRAME     = 64 * BCLK_DIV;

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    logic refclk     = 1'b0;
    logic rst        = 1'b1;
    logic pll_locked = 1'b1;
    logic bclk, lrclk, dacdat, underrun, running;
    bit   done = 1'b0;
    int   n_checks = 0;
    int   n_passed = 0;
    pair_t pending[$];

    audio_i2s_tx_if #(.DATA_W(DATA_W)) bus ();

    audio_i2s_tx #(
        .DATA_W    (DATA_W),
        .BCLK_DIV  (BCLK_DIV),
        .LOCK_WAIT (LOCK_WAIT)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .smp        (bus),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .dacdat     (dacdat),
        .underrun   (underrun),
        .running    (running)
    );

    always #5 refclk = ~refclk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Offers one pair and holds it until the handshake; keep_valid leaves valid high.
    task automatic apply_stimulus(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input bit keep_valid);
        int waited = 0;
        bit got = 1'b0;
        bus.sample_l     = l;
        bus.sample_r     = r;
        bus.sample_valid = 1'b1;
        while (!got && waited < 3 * FRAME) begin
            @(negedge refclk);
            if (bus.sample_ready) got = 1'b1;
            @(posedge refclk);
            #1;
            waited++;
        end
        if (!keep_valid) bus.sample_valid = 1'b0;
        check_output("handshake", 64'(got), 64'd1);
    endtask

    // Monitor and reference model: expectations derive from the cycle index since entering RUN.
    initial begin : monitor
        bit          m_run;
        int          m_streak;
        int          m_k;
        int          d;
        int          pos;
        int          p;
        pair_t       cur;
        logic [63:0] rx;
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] sh;
        logic        e_run, e_bclk, e_lr, e_dat, e_und, e_rdy;
        m_run    = 1'b0;
        m_streak = 0;
        m_k      = 0;
        cur      = '0;
        rx       = '0;
        d        = 0;
        @(posedge refclk);
        forever begin
            @(negedge refclk);
            if (done) break;
            e_run = 1'b0; e_bclk = 1'b0; e_lr = 1'b0; e_dat = 1'b0; e_und = 1'b0; e_rdy = 1'b0;
            if (m_run) begin
                d     = m_k % BCLK_DIV;
                pos   = (m_k / BCLK_DIV) % 64;
                e_rdy = (pending.size() == 0);
                if (m_k % FRAME == 0) begin
                    if (m_k > 0) begin
                        check_output("frame_left", 64'(rx[62 -: DATA_W]), 64'(cur.l));
                        check_output("frame_right", 64'(rx[30 -: DATA_W]), 64'(cur.r));
                    end
                    e_und = (pending.size() == 0);
                    if (pending.size() > 0) cur = pending.pop_front();
`ifndef AUDIO_TX_UNDERRUN_REPEAT_EN
                    else cur = '0;
`endif
                end
                p      = pos % 32;
                word   = (pos < 32) ? cur.l : cur.r;
                e_run  = 1'b1;
                e_bclk = (d >= BCLK_DIV / 2);
                e_lr   = (pos >= 32);
                if (p >= 1 && p <= DATA_W) begin
                    sh    = word >> (DATA_W - p);
                    e_dat = sh[0];
                end
            end
            check_output("outputs", 64'({running, bclk, lrclk, dacdat, underrun, bus.sample_ready}),
                         64'({e_run, e_bclk, e_lr, e_dat, e_und, e_rdy}));
            if (m_run && d == BCLK_DIV / 2) rx = {rx[62:0], dacdat};
            if (rst) begin
                m_run = 1'b0; m_streak = 0; m_k = 0; cur = '0; rx = '0;
                pending.delete();
            end else if (m_run) begin
                if (!pll_locked) begin
                    m_run = 1'b0; m_streak = 0; m_k = 0; cur = '0; rx = '0;
                    pending.delete();
                end else begin
                    if (bus.sample_valid && e_rdy) pending.push_back({bus.sample_l, bus.sample_r});
                    m_k++;
                end
            end else if (pll_locked) begin
                m_streak++;
                if (m_streak == LOCK_WAIT + 1) begin
                    m_run = 1'b1; m_k = 0; m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
        end
    end

    initial begin : driver
        int n;
        bus.sample_valid = 1'b0;
        bus.sample_l     = '0;
        bus.sample_r     = '0;
        repeat (3) @(posedge refclk);
        #1;
        check_output("reset_state", 64'({running, bclk, lrclk, dacdat, underrun, bus.sample_ready}), 64'd0);
        rst = 1'b0;

        // Lock glitch on the 10th cycle after reset release.
        repeat (9) @(posedge refclk);
        #1 pll_locked = 1'b0;
        @(posedge refclk);
        #1 pll_locked = 1'b1;
        n = 0;
        while (!running && n < 100) begin
            @(posedge refclk);
            #1;
            n++;
        end
        check_output("lock_delay", 64'(n), 64'd17);

        $display("[TB] known pair, then two back-to-back pairs with valid held");
        apply_stimulus(16'hA5C3, 16'h8001, 1'b0);
        apply_stimulus(16'($urandom), 16'($urandom), 1'b1);
        apply_stimulus(16'($urandom), 16'($urandom), 1'b0);
        idle_cycles(4 * FRAME);

        $display("[TB] random pairs with random gaps");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(16'($urandom), 16'($urandom), 1'b0);
            idle_cycles($urandom_range(0, FRAME));
        end

        $display("[TB] PLL drop in the right slot");
        n = 0;
        while (!lrclk && n < 2 * FRAME) begin
            @(posedge refclk);
            #1;
            n++;
        end
        check_output("reach_right_slot", 64'(lrclk), 64'd1);
        idle_cycles(40);
        pll_locked = 1'b0;
        @(posedge refclk);
        #1;
        check_output("drop_outputs", 64'({bclk, lrclk, dacdat, bus.sample_ready, running}), 64'd0);
        idle_cycles(5);
        pll_locked = 1'b1;
        n = 0;
        while (!running && n < 100) begin
            @(posedge refclk);
            #1;
            n++;
        end
        check_output("relock_delay", 64'(n), 64'(LOCK_WAIT + 1));
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(16'($urandom), 16'($urandom), 1'b0);
            idle_cycles($urandom_range(0, FRAME / 2));
        end
        idle_cycles(2 * FRAME);

        done = 1'b1;
        @(negedge refclk);
        @(negedge refclk);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end
endmodule
